sisc_mc_core: RTL and testbench
===============================

// Module: sisc_mc_core
// PURPOSE
//  Parametrised multicycle successor to the single-cycle sisc top. Owns its own PC and fetches
//  instructions from an external instruction memory over a req/ack handshake. Runs each
//  instruction through FETCH/DECODE/EXECUTE/WRITEBACK, with a generic-width register file and
//  4-bit CC status register (C,V,N,Z = bits 3..0). Adds conditional branches and halt.
// PARAMETERS
//  DATA_W  32  datapath/register width (>=16)
//  NREGS   16  register count, 2..16; register index = field mod NREGS
//  ADDR_W  16  PC / imem address width
// PORTS
//  CLK        in   1       clock, rising edge
//  RST_F      in   1       async active-low reset
//  imem_req   out  1       fetch request
//  imem_addr  out  ADDR_W  fetch address (=PC)
//  imem_ack   in   1       fetch data valid this cycle
//  imem_data  in   32      instruction word
//  halted     out  1       core in HALT state
//  illegal    out  1       sticky: undefined opcode executed
//  stat       out  4       status register {C,V,N,Z}
// BEHAVIOUR
//  Reset: all outputs 0; PC=0, IR=0, stat=0, all registers 0, state=FETCH. Reset is async and
//   may assert in any state. imem_req drops with RST_F; an ack during or after reset is ignored.
//  IR fields: op[31:28] mm[27:24] rs[23:20] rt[19:16] rd[15:12] imm[15:0].
//   imm is sign-extended to DATA_W.
//  FETCH: imem_req=1, imem_addr=PC, both held stable until imem_ack.
//   On ack: IR<=imem_data, PC<=PC+1 (mod 2^ADDR_W), ->DECODE. No timeout.
//  DECODE: A<=R[rs], B<=R[rt] ->EXECUTE.
//  EXECUTE by op:
//   0 NOP ->FETCH.
//   1 ALU reg: Y=A op B. mm: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A,
//     6 SHL A by B[4:0], 7 SHR (logical); mm>7 behaves as ADD. ->WRITEBACK, dest rd.
//   2 ALU imm: Y=A op sext(imm), same mm table ->WRITEBACK, dest rt.
//   4 BRC: taken if mm==0 or (stat & mm)!=0; if taken PC<=PC+sext(imm) (PC already +1,
//     wraps mod 2^ADDR_W) ->FETCH.
//   5 BRCN: taken if (stat & mm)==0 ->FETCH.
//   F HALT ->HALT.
//   other: illegal<=1, treat as NOP.
//  Flags for ops 1/2 are updated in EXECUTE from the full op result:
//   Z = (Y==0); N = Y[DATA_W-1]; C = carry out (ADD) / borrow (SUB) / last bit shifted out;
//   V = signed overflow for ADD/SUB, else 0.
//  WRITEBACK: R[dest]<=Y ->FETCH. Latency: 4 cycles + imem wait for ALU ops,
//   3 cycles + wait for NOP/branch.
//  HALT: terminal; halted=1, imem_req=0; exit only via RST_F.
//  Register 0 is ordinary (not hardwired).
//  Same-reg read/write cannot conflict because write and read are in different states.
// STRUCTURE
//  sisc_pkg: opcode constants, ALU mm encodings, state enum (FETCH, DECODE, EXEC, WB, HALT),
//   flag bit positions.
//  Sub-module sisc_alu_p: combinational, parametrised by DATA_W; inputs a, b, mm;
//   outputs y and flags[3:0].
//  Register file, FSM and PC stay in this module.
// TESTING
//  1. Reset mid-FETCH with imem_req=1 -> req=0 same cycle; after release PC=0, req=1, addr=0.
//  2. ADDI r1,r0,#5 then ADD r3,r1,r1 with 0-wait ack -> R3=10, stat=0000;
//     issue interval 4 cycles from ack to next req.
//  3. ADDI r2,r0,#-1 then ADDI r2,r2,#1 -> R2=0, stat Z=1, C=1, V=0.
//  4. BRC mm=0001 imm=-2 after Z set -> PC jumps back by one instruction;
//     with Z clear, falls through to PC+1.
//  5. imem_ack delayed 7 cycles -> imem_addr and imem_req held constant throughout;
//     IR loads only on ack.
//  6. Opcode 3 -> illegal=1 sticky, no register change; HALT -> halted=1 and no further req.

Source files
------------

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcodes, ALU modes, state encoding and flag positions for the sisc core
package sisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_BRC  = 4'h4;
  localparam logic [3:0] OP_BRCN = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] MM_ADD = 4'd0;
  localparam logic [3:0] MM_SUB = 4'd1;
  localparam logic [3:0] MM_AND = 4'd2;
  localparam logic [3:0] MM_OR  = 4'd3;
  localparam logic [3:0] MM_XOR = 4'd4;
  localparam logic [3:0] MM_NOT = 4'd5;
  localparam logic [3:0] MM_SHL = 4'd6;
  localparam logic [3:0] MM_SHR = 4'd7;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/sisc_alu_p.sv
// rtl/sisc_alu_p.sv - combinational parametrised ALU producing result and {C,V,N,Z}
module sisc_alu_p #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        mm,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        flags
);
  import sisc_pkg::*;

  logic [DATA_W:0] ext;
  logic [4:0]      sh;
  logic            c;
  logic            v;

  always_comb begin
    ext = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    sh  = b[4:0];
    case (mm)
      MM_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        y   = ext[DATA_W-1:0];
        c   = ext[DATA_W];
        v   = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      MM_AND: y = a & b;
      MM_OR:  y = a | b;
      MM_XOR: y = a ^ b;
      MM_NOT: y = ~a;
      // The extra bit of ext catches the last bit shifted out on either side.
      MM_SHL: begin
        ext = {1'b0, a} << sh;
        y   = ext[DATA_W-1:0];
        c   = ext[DATA_W];
      end
      MM_SHR: begin
        ext = {a, 1'b0} >> sh;
        y   = ext[DATA_W:1];
        c   = ext[0];
      end
      default: begin
        ext = {1'b0, a} + {1'b0, b};
        y   = ext[DATA_W-1:0];
        c   = ext[DATA_W];
        v   = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
    endcase
    flags         = '0;
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_N] = y[DATA_W-1];
    flags[FLAG_Z] = (y == '0);
  end

endmodule

// File: rtl/sisc_mc_core.sv
// rtl/sisc_mc_core.sv - multicycle sisc core with req/ack instruction fetch, regfile and branches
module sisc_mc_core #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST_F,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        stat
);
  import sisc_pkg::*;

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc;
  logic [31:0]         ir;
  logic [DATA_W-1:0]   a, b, y;
  logic [IDX_W-1:0]    dest;
  logic [DATA_W-1:0]   regs [NREGS];

  logic [3:0]          op, mm, rs, rt, rd;
  logic [DATA_W-1:0]   imm_sx, alu_b, alu_y;
  logic [ADDR_W-1:0]   br_off;
  logic [3:0]          alu_flags;
  logic                br_taken;

  function automatic logic [IDX_W-1:0] ridx(input logic [3:0] f);
    return IDX_W'(int'(f) % NREGS);
  endfunction

  assign op     = ir[31:28];
  assign mm     = ir[27:24];
  assign rs     = ir[23:20];
  assign rt     = ir[19:16];
  assign rd     = ir[15:12];
  assign imm_sx = DATA_W'($signed(ir[15:0]));
  assign br_off = ADDR_W'($signed(ir[15:0]));
  assign alu_b  = (op == OP_ALUI) ? imm_sx : b;

  // Request is gated by the reset pin so it falls in the same cycle reset asserts.
  assign imem_req  = RST_F && (state == ST_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  always_comb begin
    br_taken = 1'b0;
    if (op == OP_BRC)
      br_taken = (mm == 4'd0) || ((stat & mm) != 4'd0);
    else if (op == OP_BRCN)
      br_taken = ((stat & mm) == 4'd0);
  end

  sisc_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a     (a),
    .b     (alu_b),
    .mm    (mm),
    .y     (alu_y),
    .flags (alu_flags)
  );

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) state <= ST_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH:  if (imem_ack) state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_ALU, OP_ALUI: state_nx = ST_WB;
          OP_HALT:         state_nx = ST_HALT;
          default:         state_nx = ST_FETCH;
        endcase
      end
      ST_WB:     state_nx = ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      y       <= '0;
      dest    <= '0;
      stat    <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir <= imem_data;
            pc <= pc + ADDR_W'(1);
          end
        end
        ST_DECODE: begin
          a <= regs[ridx(rs)];
          b <= regs[ridx(rt)];
        end
        ST_EXEC: begin
          case (op)
            OP_ALU, OP_ALUI: begin
              y    <= alu_y;
              stat <= alu_flags;
              dest <= ridx((op == OP_ALU) ? rd : rt);
            end
            OP_BRC, OP_BRCN: if (br_taken) pc <= pc + br_off;
            OP_NOP, OP_HALT: ;
            default: illegal <= 1'b1;
          endcase
        end
        ST_WB: regs[dest] <= y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_mc_core.sv
// tb/tb_sisc_mc_core.sv - directed self-checking bench for sisc_mc_core
module tb_sisc_mc_core;

  logic        CLK = 1'b0;
  logic        RST_F;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        halted;
  logic        illegal;
  logic [3:0]  stat;

  int n_vec = 0;
  int n_bad = 0;
  int lat;

  sisc_mc_core #(.DATA_W(32), .NREGS(16), .ADDR_W(16)) dut (
    .CLK       (CLK),
    .RST_F     (RST_F),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .halted    (halted),
    .illegal   (illegal),
    .stat      (stat)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction after `waits` idle cycles; lat = cycles from ack to next request (99 = none).
  task automatic serve(input logic [31:0] instr, input int waits, output int lat_o);
    logic [15:0] addr0;
    logic [31:0] ir0;
    logic        held;
    lat_o = 99;
    if (!imem_req) begin
      chk("req_before_serve", imem_req, 1);
      return;
    end
    addr0 = imem_addr;
    ir0   = dut.ir;
    held  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      if (!imem_req || imem_addr !== addr0 || dut.ir !== ir0) held = 1'b0;
    end
    if (waits > 0) chk("held_during_wait", held, 1);
    imem_data = instr;
    imem_ack  = 1'b1;
    @(negedge CLK);
    imem_ack  = 1'b0;
    imem_data = 32'hDEAD_BEEF;
    if (waits > 0) chk("ir_on_ack", dut.ir, instr);
    for (int n = 1; n <= 12; n++) begin
      if (imem_req) begin
        lat_o = n;
        break;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_F     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_stat", stat, 4'b0000);
    RST_F = 1'b1;
    @(negedge CLK);
    chk("post_rst_req", imem_req, 1);

    serve(32'h0000_0000, 0, lat);
    chk("nop_lat", lat, 3);
    chk("nop_pc", imem_addr, 1);

    // Reset in the middle of a fetch, with an ack that must be ignored.
    RST_F     = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'h2001_0007;
    #1;
    chk("midrst_req", imem_req, 0);
    @(negedge CLK);
    @(negedge CLK);
    imem_ack = 1'b0;
    RST_F    = 1'b1;
    @(negedge CLK);
    chk("midrst_req_back", imem_req, 1);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_ir", dut.ir, 0);
    chk("midrst_r1", dut.regs[1], 0);

    serve(32'h2001_0005, 0, lat);
    chk("addi_lat", lat, 4);
    chk("r1", dut.regs[1], 5);
    serve(32'h1011_3000, 0, lat);
    chk("add_lat", lat, 4);
    chk("r3", dut.regs[3], 10);
    chk("add_stat", stat, 4'b0000);

    serve(32'h2002_FFFF, 0, lat);
    chk("r2_m1", dut.regs[2], 32'hFFFF_FFFF);
    chk("m1_stat", stat, 4'b0010);
    serve(32'h2022_0001, 0, lat);
    chk("r2_zero", dut.regs[2], 0);
    chk("wrap_stat", stat, 4'b1001);

    chk("pc_before_brc", imem_addr, 4);
    serve(32'h4100_FFFE, 0, lat);
    chk("brc_lat", lat, 3);
    chk("brc_taken_pc", imem_addr, 3);
    serve(32'h1101_4000, 0, lat);
    chk("r4_sub", dut.regs[4], 32'hFFFF_FFFB);
    chk("sub_stat", stat, 4'b1010);
    serve(32'h4100_FFFE, 0, lat);
    chk("brc_fall_pc", imem_addr, 5);
    serve(32'h5100_0003, 0, lat);
    chk("brcn_taken_pc", imem_addr, 9);

    serve(32'h2006_FFFF, 0, lat);
    serve(32'h2766_0001, 0, lat);
    chk("r6_shr", dut.regs[6], 32'h7FFF_FFFF);
    chk("shr_stat", stat, 4'b1000);
    serve(32'h2615_0004, 0, lat);
    chk("r5_shl", dut.regs[5], 32'h0000_0050);
    chk("shl_stat", stat, 4'b0000);

    serve(32'h0000_0000, 7, lat);
    chk("wait_lat", lat, 3);
    chk("wait_pc", imem_addr, 13);

    serve(32'h3011_0005, 0, lat);
    chk("illegal_set", illegal, 1);
    chk("illegal_r1", dut.regs[1], 5);
    serve(32'h0000_0000, 0, lat);
    chk("illegal_sticky", illegal, 1);

    serve(32'hF000_0000, 0, lat);
    chk("halt_no_req_lat", lat, 99);
    chk("halted", halted, 1);
    chk("halt_req", imem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
